// File: rtl/rom_pipelined_reader.sv
// Byte-addressed little-endian ROM behind a valid/ready load pipeline of LATENCY stages.
// Define ROM_ALIGN_CHECK_EN to fault misaligned half/word loads instead of assembling them.
module rom_pipelined_reader #(
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err
);

    localparam int              IDX_W             = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X           = (ADDR_W + 1)'(DEPTH);
    localparam bit              USE_DEFAULT_IMAGE = (INIT_FILE == "");

    // A non-empty INIT_FILE image is baked in by the ROM macro generator; the array is then zero here.
    function automatic logic [7:0] image_byte(input int a);
        logic [31:0] w;
        case (a / 4)
            1:       w = 32'h9912_7254;
            2:       w = 32'h1234_5678;
            3:       w = 32'h8911_7843;
            4:       w = 32'h1241_8549;
            default: w = 32'h0000_0000;
        endcase
        return USE_DEFAULT_IMAGE ? w[8*(a%4) +: 8] : 8'h00;
    endfunction

    // NOTE: ROM contents are constants, so the storage has no reset and no write port.
    logic [7:0] mem [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        assign mem[g] = image_byte(g);
    end

    logic [ADDR_W:0] nbytes;
    logic [ADDR_W:0] last_addr;
    logic            size_err;
    logic            range_err;
    logic            align_err;
    logic            req_err;
    logic [IDX_W-1:0] lane_idx;
    logic [7:0]      lane [4];
    logic [31:0]     load_data;

    // Stage-0 work: fault evaluation in ADDR_W+1 bits so an access can never wrap to address 0.
    always_comb begin
        case (req_size)
            2'd0:    nbytes = (ADDR_W + 1)'(1);
            2'd1:    nbytes = (ADDR_W + 1)'(2);
            default: nbytes = (ADDR_W + 1)'(4);
        endcase
        last_addr = {1'b0, req_addr} + nbytes - (ADDR_W + 1)'(1);
        size_err  = (req_size == 2'd3);
        range_err = (last_addr >= DEPTH_X);
        align_err = 1'b0;
`ifdef ROM_ALIGN_CHECK_EN
        align_err = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        req_err = size_err | range_err | align_err;

        lane_idx = '0;
        for (int i = 0; i < 4; i++) begin
            lane_idx = req_addr[IDX_W-1:0] + IDX_W'(i);
            lane[i]  = (!req_err && ((ADDR_W + 1)'(i) < nbytes)) ? mem[lane_idx] : 8'h00;
        end

        case (req_size)
            2'd0:    load_data = {{24{req_signed & lane[0][7]}}, lane[0]};
            2'd1:    load_data = {{16{req_signed & lane[1][7]}}, lane[1], lane[0]};
            default: load_data = {lane[3], lane[2], lane[1], lane[0]};
        endcase
    end

    logic        st_valid [LATENCY];
    logic [31:0] st_data  [LATENCY];
    logic        st_err   [LATENCY];
    logic        adv;

    assign resp_valid = st_valid[LATENCY-1];
    assign resp_data  = st_data[LATENCY-1];
    assign resp_err   = st_err[LATENCY-1];
    assign adv        = !resp_valid || resp_ready;
    assign req_ready  = adv;

    // NOTE: every stage register uses non-blocking assignment so the shift reads pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_data[i]  <= 32'h0;
                st_err[i]   <= 1'b0;
            end
        end else if (adv) begin
            // Idle slots carry zeros so undriven request fields never reach the outputs.
            st_valid[0] <= req_valid;
            st_data[0]  <= req_valid ? load_data : 32'h0;
            st_err[0]   <= req_valid & req_err;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_data[i]  <= st_data[i-1];
                st_err[i]   <= st_err[i-1];
            end
        end
    end

endmodule
